posit_to_int_slave: RTL and testbench

- Downstream stage of the integer-to-posit pipe.
- Accepts 16-bit posits (es=0) over the req/ack pipe protocol and buffers them in a small FIFO.
- Decodes each posit to an 8-bit unsigned integer (round-to-nearest-even, with clamping) and emits it on an AXI-S master interface with a one-bit status sideband.
- Closes the loop back to the 8-bit pixel domain for the vision pipeline and for round-trip checking.

---
 rtl/posit_to_int_slave.sv | 150 +++++++++++++++
 tb/tb_posit_to_int_slave.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_to_int_slave.sv
// Pipe-side slave that decodes 16-bit posits (es=0) to clamped 8-bit unsigned
// integers and queues them in a small FIFO feeding an AXI-S master.
//
// state | meaning
// IDLE  | waiting for req with FIFO space; captures pipe_read_data into in_reg
// ACK   | one-cycle ack pulse; decoded in_reg written to FIFO at cycle end
// GAP   | one idle cycle while upstream advances its data register
module posit_to_int_slave #(
  parameter int N   = 8,
  parameter int PS  = 16,
  parameter int D   = 8,
  parameter int D_S = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PS-1:0] pipe_read_data,
  input  logic          pipe_read_req,
  output logic          pipe_read_ack,
  output logic [N-1:0]  tx_axis_tdata,
  output logic          tx_axis_tuser,
  output logic          tx_axis_tvalid,
  input  logic          tx_axis_tready
);

  localparam int FW = PS - 3;
  localparam int RW = $clog2(PS) + 1;
  localparam logic signed [RW:0] K_MAX = (RW+1)'(N - 1);
  localparam logic signed [RW:0] K_M1  = (RW+1)'(-1);

  typedef enum logic [1:0] {IDLE, ACK, GAP} state_t;

  state_t        state, state_next;
  logic [PS-1:0] in_reg;
  logic          capture, wr_en, rd_en;

  logic [N-1:0]   fifo_data [D];
  logic           fifo_user [D];
  logic [D_S-1:0] wr_ptr, rd_ptr;
  logic [D_S:0]   count;

  logic [PS-2:0]    body, rem;
  logic [RW-1:0]    run_len, sh;
  logic             run_done;
  logic signed [RW:0] k;
  logic [FW:0]      mant, int_part, guard_mask, sticky_mask;
  logic             guard, sticky, round_up;
  logic [N:0]       rounded;
  logic [N-1:0]     dec_data;
  logic             dec_user;

  assign capture = (state == IDLE) && pipe_read_req && (count < (D_S+1)'(D));
  assign wr_en   = (state == ACK);
  assign rd_en   = tx_axis_tvalid && tx_axis_tready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = ACK;
      ACK:     state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pipe_read_ack = (state == ACK);
  end

  always_ff @(posedge clk) begin
    if (reset)        in_reg <= '0;
    else if (capture) in_reg <= pipe_read_data;
  end

  // Regime run, fraction alignment, then round-to-nearest-even on 1.f >> (FW-k)
  always_comb begin
    body     = in_reg[PS-2:0];
    run_len  = '0;
    run_done = 1'b0;
    for (int i = PS - 2; i >= 0; i--) begin
      if (!run_done && (body[i] == body[PS-2])) run_len = run_len + 1'b1;
      else                                      run_done = 1'b1;
    end
    rem  = body << (run_len + 1'b1);
    mant = {1'b1, rem[PS-2 -: FW]};
    k    = body[PS-2] ? ($signed({1'b0, run_len}) - (RW+1)'(1))
                      : -$signed({1'b0, run_len});
    sh          = RW'(FW) - k[RW-1:0];
    int_part    = mant >> sh;
    guard_mask  = (FW+1)'(1) << (sh - 1'b1);
    sticky_mask = guard_mask - 1'b1;
    guard       = |(mant & guard_mask);
    sticky      = |(mant & sticky_mask);
    round_up    = guard & (sticky | int_part[0]);
    rounded     = int_part[N:0] + {{N{1'b0}}, round_up};

    dec_data = '0;
    dec_user = 1'b0;
    if (in_reg[PS-1]) begin
      dec_user = 1'b1;
    end else if (body != '0) begin
      if (k > K_MAX) begin
        dec_data = '1;
        dec_user = 1'b1;
      end else if (k == K_M1) begin
        dec_data = N'(|rem[PS-2 -: FW]);
      end else if (!k[RW]) begin
        if (rounded[N]) begin
          dec_data = '1;
          dec_user = 1'b1;
        end else begin
          dec_data = rounded[N-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      fifo_data[wr_ptr] <= dec_data;
      fifo_user[wr_ptr] <= dec_user;
    end
  end

  // Gate with tvalid so the unreset storage never leaks onto the bus
  assign tx_axis_tvalid = (count != '0);
  assign tx_axis_tdata  = tx_axis_tvalid ? fifo_data[rd_ptr] : '0;
  assign tx_axis_tuser  = tx_axis_tvalid ? fifo_user[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_posit_to_int_slave.sv
// Directed bench for posit_to_int_slave: decode table, pipe handshake spacing,
// backpressure, FIFO wrap under simultaneous read/write, and reset mid-ack.
module tb_posit_to_int_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pipe_read_data;
  logic        pipe_read_req;
  logic        pipe_read_ack;
  logic [7:0]  tx_axis_tdata;
  logic        tx_axis_tuser;
  logic        tx_axis_tvalid;
  logic        tx_axis_tready;

  int errors = 0;
  int checks = 0;

  posit_to_int_slave #(.N(8), .PS(16), .D(8), .D_S(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .pipe_read_data (pipe_read_data),
    .pipe_read_req  (pipe_read_req),
    .pipe_read_ack  (pipe_read_ack),
    .tx_axis_tdata  (tx_axis_tdata),
    .tx_axis_tuser  (tx_axis_tuser),
    .tx_axis_tvalid (tx_axis_tvalid),
    .tx_axis_tready (tx_axis_tready)
  );

  always #5 clk = ~clk;

  // Stream table with hand-decoded results
  logic [15:0] wtab [10] = '{16'h4000, 16'h6000, 16'h6800, 16'h7000, 16'h7400,
                             16'hC000, 16'h7800, 16'h7C00, 16'h7E00, 16'h7F00};
  logic [7:0]  dtab [10] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd0, 8'd8, 8'd16, 8'd32, 8'd64};
  logic        utab [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  logic [15:0] words [32];
  logic [7:0]  exp_d [32];
  logic        exp_u [32];
  int n_words, idx, out_idx, ack_count;
  logic prev_ack;

  task automatic start_stream(input int n);
    for (int i = 0; i < n; i++) begin
      words[i] = wtab[i % 10];
      exp_d[i] = dtab[i % 10];
      exp_u[i] = utab[i % 10];
    end
    n_words = n; idx = 0; out_idx = 0; ack_count = 0; prev_ack = 1'b0;
    pipe_read_data = words[0];
    pipe_read_req  = 1'b1;
  endtask

  // One cycle of upstream producer + downstream consumer, evaluated at negedge.
  // mode 0: tready=0, 1: tready=1, 2: tready follows ack (read coincides with write)
  task automatic step(input int mode);
    @(negedge clk);
    if (pipe_read_ack) begin
      checks++;
      if (prev_ack) begin
        errors++;
        $display("FAIL ack_adjacent: ack=1 in two consecutive cycles, required 0 after an ack");
      end
      ack_count++;
      idx++;
      if (idx < n_words) pipe_read_data = words[idx];
      else               pipe_read_req  = 1'b0;
    end
    case (mode)
      0:       tx_axis_tready = 1'b0;
      1:       tx_axis_tready = 1'b1;
      default: tx_axis_tready = pipe_read_ack;
    endcase
    if (mode == 2 && prev_ack) begin
      checks++;
      if (dut.count !== 4'd3) begin
        errors++;
        $display("FAIL simul_count: count=%0d required 3", dut.count);
      end
    end
    prev_ack = pipe_read_ack;
    if (tx_axis_tvalid && tx_axis_tready) begin
      checks++;
      if (out_idx >= n_words) begin
        errors++;
        $display("FAIL stream_extra: unexpected word data=%0d user=%0d", tx_axis_tdata, tx_axis_tuser);
      end else if (tx_axis_tdata !== exp_d[out_idx] || tx_axis_tuser !== exp_u[out_idx]) begin
        errors++;
        $display("FAIL stream_word[%0d]: data=%0d user=%0d required data=%0d user=%0d",
                 out_idx, tx_axis_tdata, tx_axis_tuser, exp_d[out_idx], exp_u[out_idx]);
      end
      out_idx++;
    end
  endtask

  task automatic drain_and_check(input string name);
    for (int c = 0; c < 200 && out_idx < n_words; c++) step(1);
    checks++;
    if (out_idx !== n_words || ack_count !== n_words) begin
      errors++;
      $display("FAIL %s_count: out=%0d acks=%0d required %0d each", name, out_idx, ack_count, n_words);
    end
    @(negedge clk);
    checks++;
    if (tx_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s_empty: tvalid=%0b required 0", name, tx_axis_tvalid);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pipe_read_req = 1'b0;
    pipe_read_data = '0;
    tx_axis_tready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (pipe_read_ack !== 1'b0 || tx_axis_tvalid !== 1'b0 ||
        tx_axis_tdata !== 8'd0 || tx_axis_tuser !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ack=%0b tvalid=%0b tdata=%0d tuser=%0b required all 0",
               pipe_read_ack, tx_axis_tvalid, tx_axis_tdata, tx_axis_tuser);
    end
  endtask

  // One word through an empty FIFO with tready=1; checks latency and result
  task automatic send_one(input logic [15:0] w, input logic [7:0] ed, input logic eu, input string name);
    pipe_read_data = w;
    pipe_read_req  = 1'b1;
    tx_axis_tready = 1'b1;
    @(negedge clk);
    checks++;
    if (pipe_read_ack !== 1'b1 || tx_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack: ack=%0b tvalid=%0b required ack=1 tvalid=0", name, pipe_read_ack, tx_axis_tvalid);
    end
    pipe_read_req = 1'b0;
    @(negedge clk);
    checks++;
    if (pipe_read_ack !== 1'b0 || tx_axis_tvalid !== 1'b1 ||
        tx_axis_tdata !== ed || tx_axis_tuser !== eu) begin
      errors++;
      $display("FAIL %s_out: ack=%0b tvalid=%0b data=%0d user=%0b required 0 1 %0d %0b",
               name, pipe_read_ack, tx_axis_tvalid, tx_axis_tdata, tx_axis_tuser, ed, eu);
    end
    @(negedge clk);
    checks++;
    if (tx_axis_tvalid !== 1'b0 || pipe_read_ack !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: tvalid=%0b ack=%0b required 0 0", name, tx_axis_tvalid, pipe_read_ack);
    end
  endtask

  task automatic test_single();
    send_one(16'h4000, 8'd1, 1'b0, "single");
  endtask

  task automatic test_decode();
    logic [15:0] pv [9] = '{16'h6800, 16'h5000, 16'h2000, 16'h7FBF, 16'h7FC0,
                            16'h7FFF, 16'hC000, 16'h8000, 16'h0000};
    logic [7:0]  dv [9] = '{8'd3, 8'd2, 8'd0, 8'd254, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0};
    logic        uv [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) send_one(pv[i], dv[i], uv[i], $sformatf("decode_%h", pv[i]));
  endtask

  task automatic test_backpressure();
    start_stream(10);
    for (int c = 0; c < 40; c++) step(0);
    checks++;
    if (ack_count !== 8 || pipe_read_req !== 1'b1 || tx_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL full_acks: acks=%0d req=%0b tvalid=%0b required 8 1 1",
               ack_count, pipe_read_req, tx_axis_tvalid);
    end
    drain_and_check("backpressure");
  endtask

  task automatic test_ack_spacing();
    logic hist [30];
    int first;
    start_stream(20);
    for (int c = 0; c < 30; c++) begin
      step(1);
      hist[c] = pipe_read_ack;
    end
    first = -1;
    for (int c = 0; c < 30; c++) if (first < 0 && hist[c]) first = c;
    checks++;
    if (first < 0 || first > 1) begin
      errors++;
      $display("FAIL spacing_first: first ack cycle=%0d required 0 or 1", first);
    end else begin
      for (int c = first; c < 30; c++) begin
        checks++;
        if (hist[c] !== ((c - first) % 3 == 0)) begin
          errors++;
          $display("FAIL spacing_pattern: cycle %0d ack=%0b required %0b", c, hist[c], ((c - first) % 3 == 0));
        end
      end
    end
    drain_and_check("spacing");
  endtask

  task automatic test_back_to_back();
    start_stream(23);
    for (int c = 0; c < 50 && ack_count < 3; c++) step(0);
    for (int c = 0; c < 200 && idx < n_words; c++) step(2);
    checks++;
    if (out_idx !== 20) begin
      errors++;
      $display("FAIL simul_reads: reads during stream=%0d required 20", out_idx);
    end
    drain_and_check("simul");
  endtask

  task automatic test_reset_mid_ack();
    logic seen;
    pipe_read_data = 16'h6800;
    pipe_read_req  = 1'b1;
    tx_axis_tready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = pipe_read_ack;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_ack_wait: ack=0 required 1 within 10 cycles");
    end
    reset = 1'b1;
    pipe_read_req = 1'b0;
    @(negedge clk);
    checks++;
    if (pipe_read_ack !== 1'b0 || tx_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ack: ack=%0b tvalid=%0b required 0 0", pipe_read_ack, tx_axis_tvalid);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (tx_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard: tvalid=%0b data=%0d required tvalid 0", tx_axis_tvalid, tx_axis_tdata);
    end
    send_one(16'h7000, 8'd4, 1'b0, "post_reset");
  endtask

  initial begin
    reset = 1'b1;
    pipe_read_req = 1'b0;
    pipe_read_data = '0;
    tx_axis_tready = 1'b0;
    test_reset();
    test_single();
    test_decode();
    do_reset();
    test_backpressure();
    do_reset();
    test_ack_spacing();
    do_reset();
    test_back_to_back();
    do_reset();
    test_reset_mid_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
